// File: rtl/amba3_apb_slave.sv
// amba3_apb_slave: APB3 completer over a DEPTH x DATA_W register bank with run-time wait states; optional APB_PROTOCOL_CHECK_EN flags mid-ACCESS changes of paddr/pwrite/pwdata
module amba3_apb_slave #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic              psel,
  input  logic              penable,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [7:0]        wait_count,
  output logic [1:0]        out_state,
  output logic [7:0]        wait_left
);
  typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              addr_err, proto_err, commit;
  assign addr_err = 32'(addr_q) >= 32'(DEPTH);
`ifdef APB_PROTOCOL_CHECK_EN
  logic err_q, mismatch;
  assign mismatch  = state == ACCESS && (paddr != addr_q || pwrite != write_q || pwdata != wdata_q);
  assign proto_err = err_q | mismatch;
  always_ff @(posedge pclk or posedge preset)
    if (preset) err_q <= 1'b0;
    else        err_q <= next == ACCESS && proto_err;
`else
  assign proto_err = 1'b0;
`endif
  assign out_state = state;
  assign pready    = state == ACCESS && wait_left == 8'd0 && psel;
  assign pslverr   = pready && (addr_err || proto_err);
  assign commit    = pready && write_q && !pslverr;
  assign prdata    = (state == ACCESS && !write_q && !addr_err && !proto_err) ? mem[addr_q] : '0;
  always_comb begin
    next = state == IDLE   ? ((psel && !penable) ? SETUP : IDLE) :
           state == SETUP  ? (!psel ? IDLE : penable ? ACCESS : SETUP) :
           state == ACCESS ? ((!psel || wait_left == 8'd0) ? IDLE : ACCESS) : IDLE;
  end
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state     <= IDLE;
      wait_left <= 8'd0;
    end else begin
      state     <= next;
      wait_left <= (state == SETUP && next == ACCESS)  ? wait_count :
                   (state == ACCESS && next == ACCESS) ? wait_left - 8'd1 : 8'd0;
    end
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (state == SETUP) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
    end
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[addr_q] <= wdata_q;
    end
endmodule

// File: tb/tb_amba3_apb_slave.sv
// tb_amba3_apb_slave: directed table-driven bench for amba3_apb_slave
module tb_amba3_apb_slave;
  logic       pclk = 0, preset = 1;
  logic [7:0] paddr = 0, pwdata = 0, wait_count = 0;
  logic       pwrite = 0, psel = 0, penable = 0;
  logic [7:0] prdata, wait_left;
  logic       pready, pslverr;
  logic [1:0] out_state;
  int total = 0, bad = 0;

  amba3_apb_slave dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .wait_count(wait_count), .out_state(out_state), .wait_left(wait_left)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       w;
    logic [7:0] a, d, wc, exp_rd;
    logic       exp_err;
    int         stall;
    logic       hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] wc,
                      input int stall, input logic hold, input logic glitch,
                      output logic [7:0] rd, output logic er, output int lat, output logic seq_ok);
    seq_ok = 1; rd = 0; er = 0; lat = 0;
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d; wait_count = wc;
    @(posedge pclk);
    repeat (stall) @(posedge pclk);
    @(negedge pclk);
    if (stall > 0) chk("setup_stall", 32'(out_state), 32'd1);
    penable = 1;
    while (lat < 300) begin
      @(posedge pclk);
      lat++;
      if (glitch && lat == 1) begin
        #1 paddr = a ^ 8'h01;
      end
      @(negedge pclk);
      if (int'(wait_left) != int'(wc) - lat + 1) seq_ok = 0;
      if (pready) begin
        rd = prdata;
        er = pslverr;
        break;
      end
    end
    if (hold) begin
      @(posedge pclk);
      @(negedge pclk);
      chk("hold_no_restart", 32'(out_state), 32'd0);
    end
    @(posedge pclk); #1;
    psel = 0; penable = 0; paddr = a;
  endtask

  vec_t vecs[10];

  initial begin
    logic [7:0] rd;
    logic       er, seq_ok;
    int         lat;
    vecs[0] = '{1'b1, 8'h11, 8'h22, 8'd0,   8'h00, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b1, 8'h15, 8'h51, 8'd3,   8'h00, 1'b0, 0, 1'b0};
    vecs[2] = '{1'b0, 8'h11, 8'h00, 8'd0,   8'h22, 1'b0, 0, 1'b0};
    vecs[3] = '{1'b0, 8'h15, 8'h00, 8'd3,   8'h51, 1'b0, 0, 1'b0};
    vecs[4] = '{1'b0, 8'h40, 8'h00, 8'd1,   8'h00, 1'b0, 0, 1'b0};
    vecs[5] = '{1'b1, 8'hFF, 8'hA5, 8'd2,   8'h00, 1'b0, 2, 1'b0};
    vecs[6] = '{1'b0, 8'hFF, 8'h00, 8'd0,   8'hA5, 1'b0, 0, 1'b1};
    vecs[7] = '{1'b1, 8'h11, 8'h33, 8'd1,   8'h00, 1'b0, 0, 1'b1};
    vecs[8] = '{1'b0, 8'h11, 8'h00, 8'hFF,  8'h33, 1'b0, 0, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 8'h00, 8'd0,   8'h00, 1'b0, 1, 1'b0};

    #12;
    chk("rst_state", 32'(out_state), 32'd0);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_prdata", 32'(prdata), 32'd0);
    chk("rst_wait_left", 32'(wait_left), 32'd0);
    @(posedge pclk); #1 preset = 0;

    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].wc, vecs[i].stall, vecs[i].hold, 1'b0, rd, er, lat, seq_ok);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].wc) + 1);
      chk($sformatf("v%0d_wait_seq", i), 32'(seq_ok), 32'd1);
      chk($sformatf("v%0d_prdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
      @(negedge pclk);
      chk($sformatf("v%0d_idle", i), 32'(out_state), 32'd0);
      chk($sformatf("v%0d_prdata_after", i), 32'(prdata), 32'd0);
    end

    // psel dropped mid-ACCESS: abort without writing
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h60; pwdata = 8'h99; wait_count = 8'd3;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1 psel = 0;
    @(negedge pclk);
    chk("abort_pready", 32'(pready), 32'd0);
    @(posedge pclk); #1 penable = 0;
    @(negedge pclk);
    chk("abort_idle", 32'(out_state), 32'd0);
    xfer(1'b0, 8'h60, 8'h00, 8'd0, 0, 1'b0, 1'b0, rd, er, lat, seq_ok);
    chk("abort_no_write", 32'(rd), 32'd0);

`ifdef APB_PROTOCOL_CHECK_EN
    xfer(1'b1, 8'h30, 8'h77, 8'd2, 0, 1'b0, 1'b1, rd, er, lat, seq_ok);
    chk("proto_pslverr", 32'(er), 32'd1);
    chk("proto_latency", 32'(lat), 32'd3);
    xfer(1'b0, 8'h30, 8'h00, 8'd0, 0, 1'b0, 1'b0, rd, er, lat, seq_ok);
    chk("proto_no_write30", 32'(rd), 32'd0);
    chk("proto_clear", 32'(er), 32'd0);
    xfer(1'b0, 8'h31, 8'h00, 8'd0, 0, 1'b0, 1'b0, rd, er, lat, seq_ok);
    chk("proto_no_write31", 32'(rd), 32'd0);
`endif

    // reset while wait_left == 2
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h20; pwdata = 8'hAB; wait_count = 8'd5;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk);
    for (int k = 0; k < 10; k++) begin
      @(negedge pclk);
      if (wait_left == 8'd2) break;
      @(posedge pclk);
    end
    chk("pre_rst_wait_left", 32'(wait_left), 32'd2);
    preset = 1;
    #1;
    chk("midrst_state", 32'(out_state), 32'd0);
    chk("midrst_pready", 32'(pready), 32'd0);
    chk("midrst_wait_left", 32'(wait_left), 32'd0);
    psel = 0; penable = 0;
    @(posedge pclk); #1 preset = 0;
    xfer(1'b0, 8'h20, 8'h00, 8'd0, 0, 1'b0, 1'b0, rd, er, lat, seq_ok);
    chk("midrst_no_write", 32'(rd), 32'd0);
    xfer(1'b0, 8'h11, 8'h00, 8'd0, 0, 1'b0, 1'b0, rd, er, lat, seq_ok);
    chk("rst_clears_mem", 32'(rd), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
